// File: rtl/accum_arbiter.sv
// accum_arbiter
//   Round-robin arbiter that hands one requester at a time to an external
//   accumulator datapath. It performs a full enable/done handshake, captures
//   the accumulator value, and returns a one-cycle ack to the granted requester.
//   A per-phase timeout bounds each wait on a done edge.
//
// Ports
//   clk         single clock, all state on posedge
//   reset_l     asynchronous active-low reset
//   req         per-requester level request
//   add_in      packed operands, requester i at [i*ADD_WIDTH +: ADD_WIDTH]
//   ack         one-hot, one-cycle completion pulse
//   rsp_accum   accumulator value captured for the last completed grant
//   rsp_err     valid with ack, 1 = transaction timed out
//   busy        high whenever the FSM is not idle
//   err_sticky  set on any timeout, cleared only by reset
//   txn_count   completed non-error transactions (wraps)
//   acc_en      enable to the accumulator datapath
//   acc_add     operand to the accumulator datapath (latched at grant)
//   acc_done    accumulator done level
//   acc_accum   accumulator current value
module accum_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ACCUM_WIDTH = 16,
  parameter int unsigned ADD_WIDTH   = 8,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*ADD_WIDTH-1:0] add_in,
  output logic [NREQ-1:0]           ack,
  output logic [ACCUM_WIDTH-1:0]    rsp_accum,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      err_sticky,
  output logic [15:0]               txn_count,
  output logic                      acc_en,
  output logic [ADD_WIDTH-1:0]      acc_add,
  input  logic                      acc_done,
  input  logic [ACCUM_WIDTH-1:0]    acc_accum
);

  localparam int unsigned IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_ACK
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDXW-1:0]        last_grant;
  logic [IDXW-1:0]        last_grant_nxt;
  logic [7:0]             tmo_cnt;
  logic [7:0]             tmo_cnt_nxt;
  logic                   tmo_hit;

  logic                   found;
  logic [IDXW-1:0]        winner;
  logic [IDXW-1:0]        cand;

  logic                   grant_evt;
  logic                   done_ok;
  logic                   to_ack;
  logic [NREQ-1:0]        ack_nxt;
  logic [ACCUM_WIDTH-1:0] rsp_accum_nxt;
  logic                   rsp_err_nxt;
  logic                   busy_nxt;
  logic                   err_sticky_nxt;
  logic [15:0]            txn_count_nxt;
  logic                   acc_en_nxt;
  logic [ADD_WIDTH-1:0]   acc_add_nxt;

  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));

  // Round-robin search starting one past the previous winner.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    cand   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDXW'((32'(last_grant) + k) % NREQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // State register; every output is registered alongside it.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= S_IDLE;
      last_grant <= IDXW'(NREQ - 1);
      tmo_cnt    <= '0;
      ack        <= '0;
      rsp_accum  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      err_sticky <= 1'b0;
      txn_count  <= '0;
      acc_en     <= 1'b0;
      acc_add    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      ack        <= ack_nxt;
      rsp_accum  <= rsp_accum_nxt;
      rsp_err    <= rsp_err_nxt;
      busy       <= busy_nxt;
      err_sticky <= err_sticky_nxt;
      txn_count  <= txn_count_nxt;
      acc_en     <= acc_en_nxt;
      acc_add    <= acc_add_nxt;
    end
  end

  // Next-state logic. A done level already high in IDLE blocks new grants so
  // a stale done cannot be mistaken for the new transaction's handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (found && !acc_done) state_nxt = S_ISSUE;
      S_ISSUE:   if (acc_done) state_nxt = S_RELEASE;
                 else if (tmo_hit) state_nxt = S_ACK;
      S_RELEASE: if (!acc_done || tmo_hit) state_nxt = S_ACK;
      S_ACK:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic: computes the value each output register takes next cycle,
  // keyed on the transition being taken so the outputs line up with the state.
  always_comb begin
    grant_evt = (state == S_IDLE) && (state_nxt == S_ISSUE);
    done_ok   = (state == S_RELEASE) && !acc_done;
    to_ack    = (state_nxt == S_ACK);

    last_grant_nxt = last_grant;
    acc_add_nxt    = acc_add;
    if (grant_evt) begin
      last_grant_nxt = winner;
      acc_add_nxt    = add_in[32'(winner) * ADD_WIDTH +: ADD_WIDTH];
    end

    // Counter restarts whenever ISSUE or RELEASE is entered.
    if ((state_nxt == state) && ((state == S_ISSUE) || (state == S_RELEASE)))
      tmo_cnt_nxt = tmo_cnt + 8'd1;
    else
      tmo_cnt_nxt = '0;

    acc_en_nxt = (state_nxt == S_ISSUE);
    busy_nxt   = (state_nxt != S_IDLE);

    ack_nxt = '0;
    if (to_ack) ack_nxt[last_grant] = 1'b1;

    rsp_accum_nxt = rsp_accum;
    if ((state == S_ISSUE) && acc_done) rsp_accum_nxt = acc_accum;

    rsp_err_nxt    = rsp_err;
    err_sticky_nxt = err_sticky;
    txn_count_nxt  = txn_count;
    if (to_ack) begin
      rsp_err_nxt = !done_ok;
      if (done_ok) txn_count_nxt = txn_count + 16'd1;
      else         err_sticky_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_accum_arbiter.sv
// tb_accum_arbiter
//   Directed bench for accum_arbiter with a behavioural accumulator datapath,
//   a transaction-level reference model checked every cycle, and literal
//   expectations for the canonical scenarios.
module tb_accum_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 16;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              reset_l;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] add_in;
  logic [NREQ-1:0]   ack;
  logic [AW-1:0]     rsp_accum;
  logic              rsp_err;
  logic              busy;
  logic              err_sticky;
  logic [15:0]       txn_count;
  logic              acc_en;
  logic [DW-1:0]     acc_add;
  logic              acc_done;
  logic [AW-1:0]     acc_accum;

  accum_arbiter #(
    .NREQ(NREQ),
    .ACCUM_WIDTH(AW),
    .ADD_WIDTH(DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_l(reset_l),
    .req(req),
    .add_in(add_in),
    .ack(ack),
    .rsp_accum(rsp_accum),
    .rsp_err(rsp_err),
    .busy(busy),
    .err_sticky(err_sticky),
    .txn_count(txn_count),
    .acc_en(acc_en),
    .acc_add(acc_add),
    .acc_done(acc_done),
    .acc_accum(acc_accum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath: done follows en by one cycle, adds once per enable burst.
  logic          dp_done;
  logic [AW-1:0] dp_acc;
  logic          dp_tied;
  logic          dp_force;
  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      dp_done <= 1'b0;
      dp_acc  <= '0;
    end else begin
      dp_done <= acc_en && !dp_tied;
      if (acc_en && !dp_done && !dp_tied) dp_acc <= dp_acc + {8'h00, acc_add};
    end
  end
  assign acc_done  = dp_done | dp_force;
  assign acc_accum = dp_acc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int idx;
    int cyc;
    int rsp;
    int err;
    int txn;
    int sticky;
  } ack_rec_t;
  ack_rec_t log_q[$];
  int en_cnt = 0;

  // Reference model state (transaction level).
  bit        m_active;
  int        m_g0;
  int        m_gnt;
  int        m_len;
  bit        m_tmo;
  logic [7:0]  m_op;
  int        m_last;
  logic [15:0] m_txn;
  bit        m_sticky;
  logic [15:0] m_rsp;
  logic [15:0] m_acc;

  initial begin : compare
    int d;
    int pick;
    int ix;
    bit picked;
    logic [NREQ-1:0] exp_ack;
    bit exp_busy;
    bit exp_en;
    ack_rec_t r;
    m_active = 0;
    m_last   = NREQ - 1;
    m_txn    = '0;
    m_sticky = 0;
    m_rsp    = '0;
    m_acc    = '0;
    forever begin
      @(negedge clk);
      exp_ack  = '0;
      exp_busy = 0;
      exp_en   = 0;
      if (!reset_l) begin
        m_active = 0;
        m_last   = NREQ - 1;
        m_txn    = '0;
        m_sticky = 0;
        m_rsp    = '0;
        m_acc    = '0;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acc_en", 32'(acc_en), 32'd0);
        chk("rst_acc_add", 32'(acc_add), 32'd0);
        chk("rst_rsp_accum", 32'(rsp_accum), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        chk("rst_txn_count", 32'(txn_count), 32'd0);
      end else begin
        if (m_active) begin
          d        = cyc - m_g0;
          exp_busy = (d >= 1);
          exp_en   = (d >= 1) && (d <= (m_tmo ? TIMEOUT : 2));
          if (d == m_len) exp_ack[m_gnt] = 1'b1;
        end
        chk("ack", 32'(ack), 32'(exp_ack));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("acc_en", 32'(acc_en), 32'(exp_en));
        if (exp_en) chk("acc_add", 32'(acc_add), 32'(m_op));
        if (exp_ack != '0) begin
          if (m_tmo) begin
            m_sticky = 1;
          end else begin
            m_txn = m_txn + 16'd1;
            m_rsp = m_acc;
          end
          chk("rsp_err", 32'(rsp_err), 32'(m_tmo));
          chk("rsp_accum", 32'(rsp_accum), 32'(m_rsp));
          m_active = 0;
        end else if (!m_active && (req != '0) && !acc_done) begin
          picked = 0;
          pick   = 0;
          for (int k = 1; k <= NREQ; k++) begin
            ix = (m_last + k) % NREQ;
            if (!picked && req[ix]) begin
              picked = 1;
              pick   = ix;
            end
          end
          m_active = 1;
          m_g0     = cyc;
          m_gnt    = pick;
          m_last   = pick;
          m_op     = add_in[pick*DW +: DW];
          m_tmo    = dp_tied;
          m_len    = dp_tied ? TIMEOUT + 1 : 5;
          if (!dp_tied) m_acc = m_acc + {8'h00, m_op};
        end
        chk("txn_count", 32'(txn_count), 32'(m_txn));
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
      end
      if (ack != '0) begin
        r.idx = -1;
        for (int i = 0; i < NREQ; i++) if (ack[i]) r.idx = i;
        r.cyc    = cyc;
        r.rsp    = int'(rsp_accum);
        r.err    = int'(rsp_err);
        r.txn    = int'(txn_count);
        r.sticky = int'(err_sticky);
        log_q.push_back(r);
      end
      if (acc_en) en_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (log_q.size() < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (log_q.size() < target) begin
      checks++;
      errors++;
      $display("FAIL %s ack wait expired got=%0d acks exp=%0d", name, log_q.size(), target);
    end
  endtask

  task automatic get_rec(input int n, output ack_rec_t r);
    if (n < log_q.size()) r = log_q[n];
    else r = '{idx: -1, cyc: 0, rsp: -1, err: -1, txn: -1, sticky: -1};
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0;
    int base;
    int exp_idx[5];
    int exp_rsp[5];
    ack_rec_t r;
    ack_rec_t rp;
    exp_idx = '{0, 1, 2, 3, 0};
    exp_rsp = '{1, 3, 6, 10, 11};
    reset_l  = 1'b1;
    req      = '0;
    add_in   = '0;
    dp_tied  = 1'b0;
    dp_force = 1'b0;
    #2 reset_l = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_l = 1'b1;
    tick(2);

    // Single request from requester 2, operand 5.
    base = log_q.size();
    add_in[2*DW +: DW] = 8'h05;
    req = 4'b0100;
    c0 = cyc;
    tick(1);
    req = '0;
    wait_acks(base + 1, 20, "single");
    get_rec(base, r);
    chk("single_idx", 32'(r.idx), 32'd2);
    chk("single_latency", 32'(r.cyc - c0), 32'd5);
    chk("single_rsp", 32'(r.rsp), 32'h0005);
    chk("single_err", 32'(r.err), 32'd0);
    chk("single_txn", 32'(r.txn), 32'd1);
    tick(2);

    // Reset so the accumulator restarts from zero, then all four request.
    reset_l = 1'b0;
    tick(2);
    reset_l = 1'b1;
    tick(1);
    base = log_q.size();
    add_in = {8'd4, 8'd3, 8'd2, 8'd1};
    req = 4'b1111;
    c0 = cyc;
    wait_acks(base + 5, 60, "rr");
    req = '0;
    for (int k = 0; k < 5; k++) begin
      get_rec(base + k, r);
      chk("rr_idx", 32'(r.idx), 32'(exp_idx[k]));
      chk("rr_rsp", 32'(r.rsp), 32'(exp_rsp[k]));
      if (k == 0) chk("rr_first_latency", 32'(r.cyc - c0), 32'd5);
      else begin
        get_rec(base + k - 1, rp);
        chk("rr_period", 32'(r.cyc - rp.cyc), 32'd6);
      end
    end
    get_rec(base + 4, r);
    chk("rr_txn", 32'(r.txn), 32'd5);
    tick(2);

    // Datapath never answers: timeout on requester 1.
    dp_tied = 1'b1;
    base = log_q.size();
    add_in[1*DW +: DW] = 8'h07;
    req = 4'b0010;
    c0 = cyc;
    en_cnt = 0;
    tick(1);
    req = '0;
    wait_acks(base + 1, 40, "timeout");
    get_rec(base, r);
    chk("tmo_idx", 32'(r.idx), 32'd1);
    chk("tmo_latency", 32'(r.cyc - c0), 32'(TIMEOUT + 1));
    chk("tmo_err", 32'(r.err), 32'd1);
    chk("tmo_sticky", 32'(r.sticky), 32'd1);
    chk("tmo_txn", 32'(r.txn), 32'd5);
    chk("tmo_rsp_kept", 32'(r.rsp), 32'h000B);
    chk("tmo_en_cycles", 32'(en_cnt), 32'(TIMEOUT));
    dp_tied = 1'b0;
    tick(2);

    // Done already high while idle: no grant until it drops.
    base = log_q.size();
    dp_force = 1'b1;
    req = 4'b0001;
    tick(4);
    chk("done_hold_busy", 32'(busy), 32'd0);
    chk("done_hold_no_ack", 32'(log_q.size()), 32'(base));
    dp_force = 1'b0;
    c0 = cyc;
    tick(1);
    req = '0;
    wait_acks(base + 1, 20, "done_hold");
    get_rec(base, r);
    chk("done_hold_idx", 32'(r.idx), 32'd0);
    chk("done_hold_latency", 32'(r.cyc - c0), 32'd5);
    chk("done_hold_rsp", 32'(r.rsp), 32'h000C);
    chk("done_hold_txn", 32'(r.txn), 32'd6);
    tick(2);

    // Reset pulsed while in RELEASE abandons the transaction.
    base = log_q.size();
    req = 4'b0100;
    tick(1);
    req = '0;
    tick(2);
    chk("mid_busy_before", 32'(busy), 32'd1);
    reset_l = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_acc_en", 32'(acc_en), 32'd0);
    tick(1);
    reset_l = 1'b1;
    tick(6);
    chk("mid_rst_no_ack", 32'(log_q.size()), 32'(base));
    req = 4'b1001;
    c0 = cyc;
    tick(1);
    req = '0;
    wait_acks(base + 1, 20, "post_reset");
    get_rec(base, r);
    chk("post_rst_idx", 32'(r.idx), 32'd0);
    chk("post_rst_latency", 32'(r.cyc - c0), 32'd5);
    chk("post_rst_rsp", 32'(r.rsp), 32'h0001);
    chk("post_rst_txn", 32'(r.txn), 32'd1);
    chk("post_rst_sticky", 32'(r.sticky), 32'd0);
    tick(2);

    // Request dropped and operand changed right after the grant.
    base = log_q.size();
    add_in[3*DW +: DW] = 8'h10;
    req = 4'b1000;
    c0 = cyc;
    tick(1);
    req = '0;
    add_in[3*DW +: DW] = 8'hFF;
    #1;
    chk("latch_acc_add", 32'(acc_add), 32'h10);
    wait_acks(base + 1, 20, "latch");
    get_rec(base, r);
    chk("latch_idx", 32'(r.idx), 32'd3);
    chk("latch_latency", 32'(r.cyc - c0), 32'd5);
    chk("latch_rsp", 32'(r.rsp), 32'h0011);
    chk("latch_err", 32'(r.err), 32'd0);
    chk("latch_txn", 32'(r.txn), 32'd2);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
